tmds_decoder_channel: RTL

//  Receive-side counterpart of the DVI TMDS encoder: takes one lane's raw 10-bit deserialized words
//  (arbitrary bit phase) in the clk_pixel domain, finds symbol alignment from control-token runs,
//  and decodes each symbol to 8-bit pixel data or a 2-bit control code with a DE flag.

---
 rtl/tmds_decoder_channel_pkg.sv | 22 ++
 rtl/tmds_word_aligner.sv | 31 +++
 rtl/tmds_decoder_channel.sv | 138 +++++++++++++
 3 files changed

// File: rtl/tmds_decoder_channel_pkg.sv
// Shared TMDS lane definitions: control-token words, alignment FSM states, lane width.
// Imported by the word aligner and the channel decoder.
package tmds_decoder_channel_pkg;

    localparam int LANE_W = 10;

    localparam logic [LANE_W-1:0] TOKEN_C00 = 10'h354;
    localparam logic [LANE_W-1:0] TOKEN_C01 = 10'h0AB;
    localparam logic [LANE_W-1:0] TOKEN_C10 = 10'h154;
    localparam logic [LANE_W-1:0] TOKEN_C11 = 10'h2AB;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } align_state_t;

    // Bit offsets run 0..9 and wrap.
    function automatic logic [3:0] next_offset(input logic [3:0] off);
        return (off == 4'd9) ? 4'd0 : off + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// Holds the previous raw word and selects the 10-bit symbol window starting at bit `offset`.
// Latency: one register (prev); sym is combinational from in_raw/prev; no backpressure.
module tmds_word_aligner
    import tmds_decoder_channel_pkg::*;
(
    input  logic              clk_pixel,
    input  logic              reset,
    input  logic [LANE_W-1:0] in_raw,
    input  logic [3:0]        offset,
    output logic [LANE_W-1:0] sym
);

    logic [LANE_W-1:0]   prev;
    logic [2*LANE_W-1:0] window;

    always_ff @(posedge clk_pixel) begin
        if (reset) prev <= '0;
        else       prev <= in_raw;
    end

    // prev holds the earlier bits, so the window reads oldest-first from bit 0.
    assign window = {in_raw, prev};

    always_comb begin
        sym = prev;
        for (int i = 1; i < LANE_W; i++) begin
            if (offset == 4'(i)) sym = window[i +: LANE_W];
        end
    end

endmodule

// File: rtl/tmds_decoder_channel.sv
// One TMDS lane: aligns raw words via control-token runs and decodes symbols to data/control.
// Latency: 2 clk_pixel from in_raw to outputs, every cycle; no backpressure (free-running stream).
// Optional `TMDS_DECODER_LOCKLOSS_EN adds the out_lockloss saturating lock-loss counter.
module tmds_decoder_channel
    import tmds_decoder_channel_pkg::*;
#(
    parameter int C_lock_count     = 16,
    parameter int C_search_timeout = 4096,
    parameter int C_relock_timeout = 2097152
) (
    input  logic              clk_pixel,
    input  logic              reset,
    input  logic [LANE_W-1:0] in_raw,
    output logic [7:0]        out_data,
    output logic [1:0]        out_c,
    output logic              out_de,
    output logic              out_locked,
    output logic [3:0]        out_offset
`ifdef TMDS_DECODER_LOCKLOSS_EN
    ,
    output logic [15:0]       out_lockloss
`endif
);

    localparam int TIMER_MAX = (C_relock_timeout > C_search_timeout) ? C_relock_timeout
                                                                       : C_search_timeout;
    localparam int TW = $clog2(TIMER_MAX);
    localparam int RW = $clog2(C_lock_count + 1);

    logic [LANE_W-1:0] sym;
    logic              is_token;
    logic [1:0]        ctl;
    logic [7:0]        q;
    logic [7:0]        dec;

    align_state_t      state, state_d;
    logic [3:0]        offset, offset_d;
    logic [TW-1:0]     timer, timer_d;
    logic [RW-1:0]     run, run_d;
    logic              run_full;

    tmds_word_aligner u_aligner (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .in_raw    (in_raw),
        .offset    (offset),
        .sym       (sym)
    );

    always_comb begin
        is_token = 1'b1;
        ctl      = 2'b00;
        case (sym)
            TOKEN_C00: ctl = 2'b00;
            TOKEN_C01: ctl = 2'b01;
            TOKEN_C10: ctl = 2'b10;
            TOKEN_C11: ctl = 2'b11;
            default:   is_token = 1'b0;
        endcase

        // sym[9] marks an inverted payload, sym[8] selects XOR vs XNOR chaining.
        q      = sym[9] ? ~sym[7:0] : sym[7:0];
        dec    = '0;
        dec[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

    assign run_full = (run == RW'(C_lock_count));

    always_comb begin
        state_d  = state;
        offset_d = offset;
        timer_d  = timer + TW'(1);
        run_d    = is_token ? (run_full ? run : run + RW'(1)) : '0;
        // A completed token run takes priority over a timeout in the same cycle.
        case (state)
            SEARCH: begin
                if (run_full) begin
                    state_d = LOCKED;
                    timer_d = '0;
                end else if (timer == TW'(C_search_timeout - 1)) begin
                    offset_d = next_offset(offset);
                    timer_d  = '0;
                    run_d    = '0;
                end
            end
            LOCKED: begin
                if (run_full) begin
                    timer_d = '0;
                end else if (timer == TW'(C_relock_timeout - 1)) begin
                    state_d  = SEARCH;
                    offset_d = next_offset(offset);
                    timer_d  = '0;
                    run_d    = '0;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state    <= SEARCH;
            offset   <= '0;
            timer    <= '0;
            run      <= '0;
            out_data <= '0;
            out_c    <= '0;
            out_de   <= 1'b0;
        end else begin
            state    <= state_d;
            offset   <= offset_d;
            timer    <= timer_d;
            run      <= run_d;
            out_data <= is_token ? 8'h00 : dec;
            out_c    <= ctl;
            out_de   <= ~is_token;
        end
    end

    assign out_locked = (state == LOCKED);
    assign out_offset = offset;

`ifdef TMDS_DECODER_LOCKLOSS_EN
    logic lockloss_evt;
    assign lockloss_evt = (state == LOCKED) && (state_d == SEARCH);

    always_ff @(posedge clk_pixel) begin
        if (reset)
            out_lockloss <= '0;
        else if (lockloss_evt && (out_lockloss != 16'hFFFF))
            out_lockloss <= out_lockloss + 16'd1;
    end
`endif

endmodule
